rob_mw: RTL
===========

Name: rob_mw

Overview:
- Parametrised multi-width reorder buffer for the out-of-order core. Sits between rename/dispatch and commit.
- Allocates up to ALLOC_W entries in program order per cycle and marks entries complete from CMPL_W writeback lanes.
- Retires up to RET_W completed entries in order per cycle.
- Recovers in a single cycle: a branch mispredict squashes all younger entries; an excepting instruction at head flushes the whole buffer.

Parameters:
SIZE, 32, entries; power of two, >=4; IDX_W = $clog2(SIZE)
ALLOC_W, 2, allocation lanes
CMPL_W, 2, completion lanes
RET_W, 2, retire lanes
PHY_W, 6, physical register index width
PC_W, 32, PC width
EXC_W, 4, exception code width

Ports:
clock  in  1  clock
reset  in  1  reset; asynchronous, active-high
alloc_valid  in  ALLOC_W  per-lane request; contiguous from lane 0
alloc_arc_dst  in  ALLOC_W*5  architectural destination
alloc_phy_dst  in  ALLOC_W*PHY_W  new physical destination
alloc_phy_dst_old  in  ALLOC_W*PHY_W  previous mapping
alloc_pc  in  ALLOC_W*PC_W  instruction PC
alloc_ready  out  1  all lanes may allocate this cycle
alloc_rob_idx  out  ALLOC_W*IDX_W  index assigned to lane i
cmpl_valid  in  CMPL_W  completion strobe
cmpl_rob_idx  in  CMPL_W*IDX_W  completing entry
cmpl_exc_valid  in  CMPL_W  completion carries an exception
cmpl_exc_code  in  CMPL_W*EXC_W  exception code
brc_valid  in  1  mispredict strobe
brc_rob_idx  in  IDX_W  mispredicted branch entry
ret_valid  out  RET_W  retire lane valid; lanes are contiguous from lane 0
ret_arc_dst  out  RET_W*5  retiring architectural destination
ret_phy_dst  out  RET_W*PHY_W  retiring physical destination
ret_phy_dst_old  out  RET_W*PHY_W  physical register to free
exc_valid  out  1  registered one-cycle flush pulse
exc_code  out  EXC_W  code of the excepting entry
exc_pc  out  PC_W  PC of the excepting entry
squash_valid  out  1  registered one-cycle squash pulse
squash_count  out  IDX_W+1  number of entries squashed
count  out  IDX_W+1  current occupancy

Behaviour:
- Storage and pointers:
  - State: head and tail (IDX_W bits, natural wrap), count (IDX_W+1 bits), and per-entry valid, complete, exc, code, payload.
  - count alone distinguishes full (count=SIZE) from empty (count=0).
  - An entry's age offset is (idx-head) mod SIZE; the entry is live iff offset<count.
- Reset (asynchronous): head=tail=count=0; all entries cleared; exc_valid=squash_valid=0; exc_code, exc_pc, squash_count = 0.
  - Combinational outputs follow: ret_valid=0, alloc_ready=1.
- alloc_ready: asserted iff all of
  - SIZE-count >= ALLOC_W (all-or-nothing; no partial allocation), and
  - !brc_valid, and
  - the head entry is not complete-with-exception.
- alloc_rob_idx[i] = tail+i mod SIZE; combinational and always driven.
- Allocation: on a clock edge with alloc_ready && alloc_valid[0]:
  - k = popcount(alloc_valid) entries written at tail.. with valid=1, complete=0, exc=0.
  - tail advances by k.
- Completion, per lane with cmpl_valid and a live target entry:
  - Sets complete; sets exc and code when cmpl_exc_valid.
  - Completions to non-live or same-cycle-squashed entries are ignored.
  - Duplicate index in one cycle: exc is the OR of the lanes; code comes from the highest-numbered excepting lane.
  - Effect is visible next cycle, so minimum complete-to-retire latency is 1 cycle.
- Retire (combinational from registered state):
  - ret_valid[j]=1 iff j<count and entries head..head+j are all complete with exc=0.
  - Stops at the first incomplete or excepting entry.
  - On the edge, head advances by popcount(ret_valid) and those entries are invalidated. No backpressure.
- Exception: the head entry is live, complete, and exc=1. On that edge:
  - All entries invalidated; tail=head; count=0.
  - Next cycle exc_valid=1 with that entry's code and PC; exc_valid is low otherwise.
  - Retire lanes are 0 in this cycle; same-cycle completions and branch are discarded.
  - Flush has priority over squash.
- Branch mispredict: brc_valid with a live brc_rob_idx, no flush.
  - Entries with offset > offset(brc_rob_idx) are invalidated.
  - tail = brc_rob_idx+1.
  - Next cycle squash_valid=1 with squash_count = number killed (0 allowed).
  - Retire proceeds in the same cycle.
  - A non-live brc_rob_idx is ignored and no pulse is produced.
- count_next = count + allocated - retired - squashed (or 0 on flush). It never exceeds SIZE.
- Wrap-around: all index arithmetic is modulo SIZE. An allocation group or retire group may straddle index SIZE-1 to 0.

Test Plan:
1. Reset, allocate 2/cycle for 16 cycles, no completions -> count=32, alloc_ready=0; alloc_rob_idx of the last group = {30,31}.
2. From state 1, complete idx 0 and 1 in one cycle -> the next cycle ret_valid=2'b11 with idx 0/1 payload; count=30; alloc_ready=1 the following cycle.
3. Head=30, entries 30,31,0 complete -> retire 30,31 in the first cycle and 0 in the next; head wraps to 1; payloads correct.
4. Entries 0..9 live; brc_rob_idx=3 while idx 0 retires -> tail=4, count=3, squash_valid pulse with squash_count=6; a completion to idx 5 in the same cycle is ignored.
5. Head idx 4 completes with exc code 4'hB at PC 0x100 while brc_valid targets idx 6 -> flush: count=0, exc_valid pulse with code 0xB and pc 0x100, squash_valid stays 0.
6. Assert reset mid-flush (while exc_valid=1) -> all outputs are immediately at reset values without waiting for clock; alloc_ready=1.

Source files
------------

// File: rtl/rob_mw_if.sv
// Reorder-buffer interface: allocation, completion, recovery and retire
// bundles shared between the dispatch/commit side and the ROB.
interface rob_mw_if #(
  parameter int SIZE    = 32,
  parameter int ALLOC_W = 2,
  parameter int CMPL_W  = 2,
  parameter int RET_W   = 2,
  parameter int PHY_W   = 6,
  parameter int PC_W    = 32,
  parameter int EXC_W   = 4
);
  localparam int IDX_W = $clog2(SIZE);

  logic [ALLOC_W-1:0]       alloc_valid;
  logic [ALLOC_W*5-1:0]     alloc_arc_dst;
  logic [ALLOC_W*PHY_W-1:0] alloc_phy_dst;
  logic [ALLOC_W*PHY_W-1:0] alloc_phy_dst_old;
  logic [ALLOC_W*PC_W-1:0]  alloc_pc;
  logic                     alloc_ready;
  logic [ALLOC_W*IDX_W-1:0] alloc_rob_idx;

  logic [CMPL_W-1:0]        cmpl_valid;
  logic [CMPL_W*IDX_W-1:0]  cmpl_rob_idx;
  logic [CMPL_W-1:0]        cmpl_exc_valid;
  logic [CMPL_W*EXC_W-1:0]  cmpl_exc_code;

  logic                     brc_valid;
  logic [IDX_W-1:0]         brc_rob_idx;

  logic [RET_W-1:0]         ret_valid;
  logic [RET_W*5-1:0]       ret_arc_dst;
  logic [RET_W*PHY_W-1:0]   ret_phy_dst;
  logic [RET_W*PHY_W-1:0]   ret_phy_dst_old;

  logic                     exc_valid;
  logic [EXC_W-1:0]         exc_code;
  logic [PC_W-1:0]          exc_pc;
  logic                     squash_valid;
  logic [IDX_W:0]           squash_count;
  logic [IDX_W:0]           count;

  modport master (
    output alloc_valid, alloc_arc_dst, alloc_phy_dst, alloc_phy_dst_old, alloc_pc,
    output cmpl_valid, cmpl_rob_idx, cmpl_exc_valid, cmpl_exc_code,
    output brc_valid, brc_rob_idx,
    input  alloc_ready, alloc_rob_idx,
    input  ret_valid, ret_arc_dst, ret_phy_dst, ret_phy_dst_old,
    input  exc_valid, exc_code, exc_pc, squash_valid, squash_count, count
  );

  modport slave (
    input  alloc_valid, alloc_arc_dst, alloc_phy_dst, alloc_phy_dst_old, alloc_pc,
    input  cmpl_valid, cmpl_rob_idx, cmpl_exc_valid, cmpl_exc_code,
    input  brc_valid, brc_rob_idx,
    output alloc_ready, alloc_rob_idx,
    output ret_valid, ret_arc_dst, ret_phy_dst, ret_phy_dst_old,
    output exc_valid, exc_code, exc_pc, squash_valid, squash_count, count
  );
endinterface

// File: rtl/rob_mw.sv
// Multi-width reorder buffer: in-order allocate/retire, out-of-order
// completion, single-cycle branch squash and exception flush.
module rob_mw #(
  parameter int SIZE    = 32,
  parameter int ALLOC_W = 2,
  parameter int CMPL_W  = 2,
  parameter int RET_W   = 2,
  parameter int PHY_W   = 6,
  parameter int PC_W    = 32,
  parameter int EXC_W   = 4
) (
  input logic   clock,
  input logic   reset,
  rob_mw_if.slave bus
);
  localparam int IDX_W = $clog2(SIZE);
  localparam int CW    = IDX_W + 1;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [CW-1:0]    cnt_t;

  idx_t head_q, head_d, tail_q, tail_d;
  cnt_t count_q, count_d;
  logic [SIZE-1:0] vld_q, vld_d, cmp_q, cmp_d, exc_q, exc_d;
  logic [EXC_W-1:0] code_q [SIZE];
  logic [EXC_W-1:0] code_d [SIZE];
  logic [4:0]       arc_q  [SIZE];
  logic [4:0]       arc_d  [SIZE];
  logic [PHY_W-1:0] phy_q  [SIZE];
  logic [PHY_W-1:0] phy_d  [SIZE];
  logic [PHY_W-1:0] old_q  [SIZE];
  logic [PHY_W-1:0] old_d  [SIZE];
  logic [PC_W-1:0]  pc_q   [SIZE];
  logic [PC_W-1:0]  pc_d   [SIZE];
  logic             exc_valid_q, exc_valid_d, squash_valid_q, squash_valid_d;
  logic [EXC_W-1:0] exc_code_q, exc_code_d;
  logic [PC_W-1:0]  exc_pc_q, exc_pc_d;
  cnt_t             squash_count_q, squash_count_d;

  logic             flush, brc_live, alloc_rdy, alloc_fire, ok;
  idx_t             brc_off, ci, ai;
  cnt_t             sq_cnt, n_ret, n_alloc;
  logic [RET_W-1:0] ret_v;

  // An entry is live when its age offset from head is below the occupancy.
  function automatic logic is_live(idx_t idx, idx_t hd, cnt_t cnt);
    idx_t off;
    off = idx - hd;
    return {1'b0, off} < cnt;
  endfunction

  // Decode flush/squash conditions, retire lanes and allocation acceptance.
  always_comb begin
    flush    = (count_q != '0) && vld_q[head_q] && cmp_q[head_q] && exc_q[head_q];
    brc_off  = bus.brc_rob_idx - head_q;
    brc_live = bus.brc_valid && is_live(bus.brc_rob_idx, head_q, count_q);
    sq_cnt   = count_q - cnt_t'(brc_off) - cnt_t'(1);
    ok       = 1'b1;
    n_ret    = '0;
    for (int j = 0; j < RET_W; j++) begin
      // Lanes younger than a mispredicted branch are about to die; never retire them.
      ok = ok && (cnt_t'(j) < count_q) && cmp_q[head_q + idx_t'(j)] &&
           !exc_q[head_q + idx_t'(j)] && !(brc_live && (idx_t'(j) > brc_off));
      ret_v[j] = ok;
      n_ret    = n_ret + cnt_t'(ok);
    end
    alloc_rdy  = (count_q <= cnt_t'(SIZE - ALLOC_W)) && !bus.brc_valid && !flush;
    alloc_fire = alloc_rdy && bus.alloc_valid[0];
    n_alloc    = '0;
    for (int i = 0; i < ALLOC_W; i++) n_alloc = n_alloc + cnt_t'(bus.alloc_valid[i]);
  end

  // Next-state: flush wins; otherwise completion, retire, squash, allocate.
  always_comb begin
    head_d = head_q;  tail_d = tail_q;  count_d = count_q;
    vld_d  = vld_q;   cmp_d  = cmp_q;   exc_d   = exc_q;
    code_d = code_q;  arc_d  = arc_q;   phy_d   = phy_q;
    old_d  = old_q;   pc_d   = pc_q;
    exc_valid_d    = 1'b0;
    exc_code_d     = exc_code_q;
    exc_pc_d       = exc_pc_q;
    squash_valid_d = 1'b0;
    squash_count_d = squash_count_q;
    ci = '0;
    ai = '0;
    if (flush) begin
      vld_d       = '0;
      cmp_d       = '0;
      exc_d       = '0;
      tail_d      = head_q;
      count_d     = '0;
      exc_valid_d = 1'b1;
      exc_code_d  = code_q[head_q];
      exc_pc_d    = pc_q[head_q];
    end else begin
      // Higher lanes overwrite the code, so the highest excepting lane wins.
      for (int i = 0; i < CMPL_W; i++) begin
        ci = bus.cmpl_rob_idx[i*IDX_W +: IDX_W];
        if (bus.cmpl_valid[i] && is_live(ci, head_q, count_q) && vld_q[ci] &&
            !(brc_live && ((ci - head_q) > brc_off))) begin
          cmp_d[ci] = 1'b1;
          if (bus.cmpl_exc_valid[i]) begin
            exc_d[ci]  = 1'b1;
            code_d[ci] = bus.cmpl_exc_code[i*EXC_W +: EXC_W];
          end
        end
      end
      for (int j = 0; j < RET_W; j++) begin
        if (ret_v[j]) begin
          vld_d[head_q + idx_t'(j)] = 1'b0;
          cmp_d[head_q + idx_t'(j)] = 1'b0;
          exc_d[head_q + idx_t'(j)] = 1'b0;
        end
      end
      head_d = head_q + idx_t'(n_ret);
      if (brc_live) begin
        for (int s = 0; s < SIZE; s++) begin
          if ((idx_t'(s) - head_q) > brc_off) begin
            vld_d[s] = 1'b0;
            cmp_d[s] = 1'b0;
            exc_d[s] = 1'b0;
          end
        end
        tail_d         = bus.brc_rob_idx + idx_t'(1);
        squash_valid_d = 1'b1;
        squash_count_d = sq_cnt;
        count_d        = count_q - n_ret - sq_cnt;
      end else if (alloc_fire) begin
        for (int i = 0; i < ALLOC_W; i++) begin
          ai = tail_q + idx_t'(i);
          if (bus.alloc_valid[i]) begin
            vld_d[ai]  = 1'b1;
            cmp_d[ai]  = 1'b0;
            exc_d[ai]  = 1'b0;
            code_d[ai] = '0;
            arc_d[ai]  = bus.alloc_arc_dst[i*5 +: 5];
            phy_d[ai]  = bus.alloc_phy_dst[i*PHY_W +: PHY_W];
            old_d[ai]  = bus.alloc_phy_dst_old[i*PHY_W +: PHY_W];
            pc_d[ai]   = bus.alloc_pc[i*PC_W +: PC_W];
          end
        end
        tail_d  = tail_q + idx_t'(n_alloc);
        count_d = count_q + n_alloc - n_ret;
      end else begin
        count_d = count_q - n_ret;
      end
    end
  end

  // State registers; every field returns to zero on reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q <= '0; tail_q <= '0; count_q <= '0;
      vld_q  <= '0; cmp_q  <= '0; exc_q   <= '0;
      for (int i = 0; i < SIZE; i++) begin
        code_q[i] <= '0; arc_q[i] <= '0; phy_q[i] <= '0;
        old_q[i]  <= '0; pc_q[i]  <= '0;
      end
      exc_valid_q    <= 1'b0; exc_code_q <= '0; exc_pc_q <= '0;
      squash_valid_q <= 1'b0; squash_count_q <= '0;
    end else begin
      head_q <= head_d; tail_q <= tail_d; count_q <= count_d;
      vld_q  <= vld_d;  cmp_q  <= cmp_d;  exc_q   <= exc_d;
      code_q <= code_d; arc_q  <= arc_d;  phy_q   <= phy_d;
      old_q  <= old_d;  pc_q   <= pc_d;
      exc_valid_q    <= exc_valid_d; exc_code_q <= exc_code_d; exc_pc_q <= exc_pc_d;
      squash_valid_q <= squash_valid_d; squash_count_q <= squash_count_d;
    end
  end

  assign bus.alloc_ready  = alloc_rdy;
  assign bus.ret_valid    = ret_v;
  assign bus.exc_valid    = exc_valid_q;
  assign bus.exc_code     = exc_code_q;
  assign bus.exc_pc       = exc_pc_q;
  assign bus.squash_valid = squash_valid_q;
  assign bus.squash_count = squash_count_q;
  assign bus.count        = count_q;

  for (genvar i = 0; i < ALLOC_W; i++) begin : g_aidx
    assign bus.alloc_rob_idx[i*IDX_W +: IDX_W] = tail_q + idx_t'(i);
  end

  for (genvar j = 0; j < RET_W; j++) begin : g_ret
    assign bus.ret_arc_dst[j*5 +: 5]             = arc_q[head_q + idx_t'(j)];
    assign bus.ret_phy_dst[j*PHY_W +: PHY_W]     = phy_q[head_q + idx_t'(j)];
    assign bus.ret_phy_dst_old[j*PHY_W +: PHY_W] = old_q[head_q + idx_t'(j)];
  end
endmodule
